// File: rtl/motor_cmd_scheduler_pkg.sv
// Shared types for the pan/tilt motor command scheduler.
// HOME_ON_LOST_EN adds the homing states to the FSM encoding.
package motor_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StSend1,
        StSend2
`ifdef HOME_ON_LOST_EN
        ,
        StHomeP,
        StHomeT
`endif
    } state_e;

    typedef enum logic {
        AXIS_PAN  = 1'b0,
        AXIS_TILT = 1'b1
    } axis_e;

    typedef struct packed {
        axis_e      axis;
        logic       dir;
        logic [7:0] steps;
        logic       home;
    } cmd_t;

endpackage

// File: rtl/motor_cmd_scheduler_if.sv
// Valid/ready motor-command channel between the scheduler and the motor driver link.
interface motor_cmd_if;
    import motor_sched_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    axis_e      cmd_axis;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       cmd_home;

    modport master (
        output cmd_valid, cmd_axis, cmd_dir, cmd_steps, cmd_home,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_axis, cmd_dir, cmd_steps, cmd_home,
        output cmd_ready
    );

endinterface

// File: rtl/motor_cmd_scheduler_axis_err_calc.sv
// Combinational per-axis error: signed offset from centre, magnitude, deadband test
// and saturated step count.
module axis_err_calc
    import motor_sched_pkg::*;
#(
    parameter int unsigned CENTER     = 320,
    parameter int unsigned DEADBAND   = 8,
    parameter int unsigned GAIN_SHIFT = 2,
    parameter int unsigned MAX_STEP   = 64
) (
    input  logic [9:0] pos_i,
    output logic       dir_o,
    output logic       active_o,
    output logic [9:0] mag_o,
    output logic [7:0] steps_o
);

    logic signed [10:0] err;
    logic [9:0]         shifted;

    always_comb begin
        err      = $signed({1'b0, pos_i}) - $signed(11'(CENTER));
        mag_o    = err[10] ? 10'(-err) : 10'(err);
        dir_o    = ~err[10];
        active_o = mag_o > 10'(DEADBAND);
        shifted  = mag_o >> GAIN_SHIFT;
        if (shifted > 10'(MAX_STEP)) begin
            steps_o = 8'(MAX_STEP);
        end else begin
            steps_o = shifted[7:0];
        end
        // A move outside the deadband always issues at least one step.
        if (active_o && steps_o == 8'd0) begin
            steps_o = 8'd1;
        end
    end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Per-frame pan/tilt step scheduler: samples the locked centroid once per frame and
// serialises up to two step commands. Define HOME_ON_LOST_EN to home after lost frames.
module motor_cmd_scheduler
    import motor_sched_pkg::*;
#(
    parameter int unsigned CENTER_X    = 320,
    parameter int unsigned CENTER_Y    = 240,
    parameter int unsigned DEADBAND    = 8,
    parameter int unsigned GAIN_SHIFT  = 2,
    parameter int unsigned MAX_STEP    = 64,
    parameter int unsigned TIMEOUT_CYC = 100000
`ifdef HOME_ON_LOST_EN
    ,
    parameter int unsigned LOST_FRAMES = 30
`endif
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        frame_done_i,
    input  logic        is_locked_i,
    input  logic        target_valid_i,
    input  logic [9:0]  target_x_i,
    input  logic [9:0]  target_y_i,
    motor_cmd_if.master cmd_if,
    output logic        busy_o,
    output logic        err_timeout_o,
    input  logic        clear_err_i,
    output logic [7:0]  overrun_cnt_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    state_e          state_q;
    logic [9:0]      x_q, y_q;
    cmd_t            cmd_q, second_q;
    logic            valid_q, has2_q, skip_q, busy_q, err_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      ovr_q;

    logic       pan_dir, pan_act, tilt_dir, tilt_act;
    logic [9:0] pan_mag, tilt_mag;
    logic [7:0] pan_steps, tilt_steps;
    cmd_t       pan_cmd, tilt_cmd, first_cmd, second_cmd;
    logic       tilt_first, any_act, both_act, xfer, tmo_hit;

    axis_err_calc #(
        .CENTER     (CENTER_X),
        .DEADBAND   (DEADBAND),
        .GAIN_SHIFT (GAIN_SHIFT),
        .MAX_STEP   (MAX_STEP)
    ) u_pan (
        .pos_i    (x_q),
        .dir_o    (pan_dir),
        .active_o (pan_act),
        .mag_o    (pan_mag),
        .steps_o  (pan_steps)
    );

    axis_err_calc #(
        .CENTER     (CENTER_Y),
        .DEADBAND   (DEADBAND),
        .GAIN_SHIFT (GAIN_SHIFT),
        .MAX_STEP   (MAX_STEP)
    ) u_tilt (
        .pos_i    (y_q),
        .dir_o    (tilt_dir),
        .active_o (tilt_act),
        .mag_o    (tilt_mag),
        .steps_o  (tilt_steps)
    );

    always_comb begin
        pan_cmd    = '{axis: AXIS_PAN,  dir: pan_dir,  steps: pan_steps,  home: 1'b0};
        tilt_cmd   = '{axis: AXIS_TILT, dir: tilt_dir, steps: tilt_steps, home: 1'b0};
        // Larger error goes first; a tie keeps pan first.
        tilt_first = tilt_act && (!pan_act || tilt_mag > pan_mag);
        first_cmd  = tilt_first ? tilt_cmd : pan_cmd;
        second_cmd = tilt_first ? pan_cmd : tilt_cmd;
        any_act    = pan_act | tilt_act;
        both_act   = pan_act & tilt_act;
        xfer       = valid_q & cmd_if.cmd_ready;
        tmo_hit    = valid_q & ~cmd_if.cmd_ready & (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    end

`ifdef HOME_ON_LOST_EN
    localparam int unsigned LostW = $clog2(LOST_FRAMES + 1);
    logic [LostW-1:0] lost_q;
    logic             armed_q;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            cmd_q    <= '0;
            second_q <= '0;
            valid_q  <= 1'b0;
            has2_q   <= 1'b0;
            skip_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            ovr_q    <= '0;
`ifdef HOME_ON_LOST_EN
            lost_q   <= '0;
            armed_q  <= 1'b1;
`endif
        end else begin
            if (frame_done_i && state_q != StIdle && ovr_q != 8'hff) begin
                ovr_q <= ovr_q + 8'd1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (clear_err_i) begin
                err_q <= 1'b0;
            end
            // Restarts on every accepted command so each one gets its own budget.
            if (valid_q && !xfer) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (frame_done_i && is_locked_i && target_valid_i) begin
                        x_q     <= target_x_i;
                        y_q     <= target_y_i;
                        state_q <= StCalc;
                        busy_q  <= 1'b1;
                    end
`ifdef HOME_ON_LOST_EN
                    if (frame_done_i) begin
                        if (is_locked_i) begin
                            lost_q  <= '0;
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            if (lost_q == LostW'(LOST_FRAMES - 1)) begin
                                lost_q  <= '0;
                                armed_q <= 1'b0;
                                cmd_q   <= '{axis: AXIS_PAN, dir: 1'b0, steps: 8'd0, home: 1'b1};
                                valid_q <= 1'b1;
                                state_q <= StHomeP;
                                busy_q  <= 1'b1;
                            end else begin
                                lost_q <= lost_q + 1'b1;
                            end
                        end
                    end
`endif
                end
                StCalc: begin
                    skip_q <= 1'b0;
                    if (!any_act) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cmd_q    <= first_cmd;
                        second_q <= second_cmd;
                        has2_q   <= both_act;
                        valid_q  <= 1'b1;
                        state_q  <= StSend1;
                    end
                end
                StSend1: begin
                    if (!is_locked_i) begin
                        skip_q <= 1'b1;
                    end
                    if (tmo_hit) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
                        if (has2_q && !skip_q && is_locked_i) begin
                            cmd_q   <= second_q;
                            state_q <= StSend2;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StSend2: begin
                    if (tmo_hit || xfer) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
`ifdef HOME_ON_LOST_EN
                StHomeP: begin
                    if (tmo_hit) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
                        cmd_q   <= '{axis: AXIS_TILT, dir: 1'b0, steps: 8'd0, home: 1'b1};
                        state_q <= StHomeT;
                    end
                end
                StHomeT: begin
                    if (tmo_hit || xfer) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd_axis  = cmd_q.axis;
    assign cmd_if.cmd_dir   = cmd_q.dir;
    assign cmd_if.cmd_steps = cmd_q.steps;
    assign cmd_if.cmd_home  = cmd_q.home;
    assign busy_o           = busy_q;
    assign err_timeout_o    = err_q;
    assign overrun_cnt_o    = ovr_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed self-checking bench for motor_cmd_scheduler (short timeout for simulation).
module tb_motor_cmd_scheduler;
    import motor_sched_pkg::*;

    localparam int unsigned Tmo = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_done = 1'b0;
    logic       is_locked = 1'b0;
    logic       target_valid = 1'b0;
    logic [9:0] target_x = '0;
    logic [9:0] target_y = '0;
    logic       busy, err_timeout;
    logic       clear_err = 1'b0;
    logic [7:0] overrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

    motor_cmd_if cmd_if ();

    motor_cmd_scheduler #(
        .TIMEOUT_CYC (Tmo)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .frame_done_i   (frame_done),
        .is_locked_i    (is_locked),
        .target_valid_i (target_valid),
        .target_x_i     (target_x),
        .target_y_i     (target_y),
        .cmd_if         (cmd_if),
        .busy_o         (busy),
        .err_timeout_o  (err_timeout),
        .clear_err_i    (clear_err),
        .overrun_cnt_o  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_done with a locked target; returns one cycle after the sampling edge (CALC).
    task automatic fire(input logic [9:0] x, input logic [9:0] y);
        target_x     = x;
        target_y     = y;
        is_locked    = 1'b1;
        target_valid = 1'b1;
        frame_done   = 1'b1;
        tick();
        frame_done   = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic axis, input logic dir,
                             input logic [7:0] steps, input logic home);
        check_eq({tag, ".valid"}, 32'(cmd_if.cmd_valid), 32'd1);
        check_eq({tag, ".axis"},  32'(cmd_if.cmd_axis),  32'(axis));
        check_eq({tag, ".dir"},   32'(cmd_if.cmd_dir),   32'(dir));
        check_eq({tag, ".steps"}, 32'(cmd_if.cmd_steps), 32'(steps));
        check_eq({tag, ".home"},  32'(cmd_if.cmd_home),  32'(home));
    endtask

    task automatic accept();
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  vcnt;
        logic fell, err_at_fall;

        cmd_if.cmd_ready = 1'b0;
        #12 reset_n = 1'b1;
        tick();
        check_eq("rst.valid", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.err", 32'(err_timeout), 32'd0);
        check_eq("rst.ovr", 32'(overrun_cnt), 32'd0);
        check_eq("rst.home", 32'(cmd_if.cmd_home), 32'd0);

        // Single pan command, latency frame+2, valid drops after transfer.
        fire(10'd400, 10'd240);
        check_eq("t1.calc_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("t1.calc_busy", 32'(busy), 32'd1);
        tick();
        check_cmd("t1", 1'b0, 1'b1, 8'd20, 1'b0);
        accept();
        check_eq("t1.valid_after", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("t1.busy_after", 32'(busy), 32'd0);

        // Tilt larger: tilt first, payload stable while stalled, then pan.
        tick();
        fire(10'd300, 10'd140);
        tick();
        check_cmd("t2a", 1'b1, 1'b0, 8'd25, 1'b0);
        tick();
        check_cmd("t2a_hold", 1'b1, 1'b0, 8'd25, 1'b0);
        accept();
        check_cmd("t2b", 1'b0, 1'b0, 8'd5, 1'b0);
        accept();
        check_eq("t2.valid_after", 32'(cmd_if.cmd_valid), 32'd0);

        // Tie goes pan first.
        tick();
        fire(10'd330, 10'd250);
        tick();
        check_cmd("t3a", 1'b0, 1'b1, 8'd2, 1'b0);
        accept();
        check_cmd("t3b", 1'b1, 1'b1, 8'd2, 1'b0);
        accept();
        check_eq("t3.valid_after", 32'(cmd_if.cmd_valid), 32'd0);

        // Deadband: one CALC cycle then idle, no command.
        tick();
        fire(10'd325, 10'd245);
        check_eq("t4.busy_calc", 32'(busy), 32'd1);
        tick();
        check_eq("t4.busy_after", 32'(busy), 32'd0);
        check_eq("t4.valid", 32'(cmd_if.cmd_valid), 32'd0);

        // Timeout with clear_err held high, plus three overrun frames while stalled.
        tick();
        fire(10'd300, 10'd140);
        tick();
        check_cmd("t5", 1'b1, 1'b0, 8'd25, 1'b0);
        clear_err   = 1'b1;
        vcnt        = 1;
        fell        = 1'b0;
        err_at_fall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            frame_done = (i == 3 || i == 5 || i == 7);
            tick();
            frame_done = 1'b0;
            if (cmd_if.cmd_valid) vcnt++;
            if (!fell && !cmd_if.cmd_valid) begin
                fell        = 1'b1;
                err_at_fall = err_timeout;
                clear_err   = 1'b0;
            end
        end
        check_eq("t5.valid_cycles", 32'(vcnt), 32'(Tmo));
        check_eq("t5.err_set_wins", 32'(err_at_fall), 32'd1);
        check_eq("t5.err_sticky", 32'(err_timeout), 32'd1);
        check_eq("t5.busy", 32'(busy), 32'd0);
        check_eq("t6.overrun", 32'(overrun_cnt), 32'd3);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_eq("t5.err_cleared", 32'(err_timeout), 32'd0);

        // Saturation at MAX_STEP.
        fire(10'd0, 10'd240);
        tick();
        check_cmd("t7", 1'b0, 1'b0, 8'd64, 1'b0);
        accept();
        check_eq("t7.valid_after", 32'(cmd_if.cmd_valid), 32'd0);

        // Lock lost during SEND1: first completes, second skipped.
        tick();
        fire(10'd300, 10'd140);
        tick();
        check_cmd("t8", 1'b1, 1'b0, 8'd25, 1'b0);
        is_locked = 1'b0;
        tick();
        is_locked = 1'b1;
        accept();
        check_eq("t8.skip_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("t8.skip_busy", 32'(busy), 32'd0);

        // Async reset mid-transfer.
        tick();
        fire(10'd400, 10'd240);
        tick();
        check_cmd("t9", 1'b0, 1'b1, 8'd20, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t9.rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("t9.rst_busy", 32'(busy), 32'd0);
        check_eq("t9.rst_ovr", 32'(overrun_cnt), 32'd0);
        #2 reset_n = 1'b1;
        tick();
        check_eq("t9.post_valid", 32'(cmd_if.cmd_valid), 32'd0);

`ifdef HOME_ON_LOST_EN
        is_locked = 1'b0;
        for (int f = 0; f < 30; f++) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            if (f < 29) tick();
        end
        check_cmd("h.pan", 1'b0, 1'b0, 8'd0, 1'b1);
        accept();
        check_cmd("h.tilt", 1'b1, 1'b0, 8'd0, 1'b1);
        accept();
        check_eq("h.valid_after", 32'(cmd_if.cmd_valid), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        check_eq("h.no_repeat", 32'(cmd_if.cmd_valid), 32'd0);
        check_eq("h.no_repeat_busy", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
